// File: rtl/dram_arbiter_pkg.sv
// Shared definitions for the DRAMCON user-port arbiter: request codes,
// arbiter state encoding and a request-validity helper.
package dram_arbiter_pkg;

  // Request codes presented by requesters and forwarded to DRAMCON.
  typedef enum logic [1:0] {
    REQ_NONE  = 2'b00,
    REQ_READ  = 2'b01,
    REQ_WRITE = 2'b10,
    REQ_RSVD  = 2'b11
  } req_e;

  // Arbiter transaction phases.
  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAITHI,
    WAITLO
  } arb_state_e;

  // Only read and write are real requests; the reserved code counts as none.
  function automatic logic is_valid_req(input logic [1:0] code);
    return (code == REQ_READ) || (code == REQ_WRITE);
  endfunction

endpackage

// File: rtl/dram_arbiter_if.sv
// Bundle of requester-side and DRAMCON-side signals around the arbiter.
// slave: the arbiter's view; master: the view of the surrounding logic.
interface dram_arbiter_if #(
  parameter int DATA_W = 512,
  parameter int ADDR_W = 32
);

  // Requester 0 (sort core)
  logic [1:0]        R0_REQ;
  logic [ADDR_W-1:0] R0_INITADR;
  logic [ADDR_W-1:0] R0_BLOCKS;
  logic [DATA_W-1:0] R0_DIN;
  logic              R0_ACK;
  logic              R0_W;
  logic              R0_DOUTEN;

  // Requester 1 (read-back / LCD dump)
  logic [1:0]        R1_REQ;
  logic [ADDR_W-1:0] R1_INITADR;
  logic [ADDR_W-1:0] R1_BLOCKS;
  logic [DATA_W-1:0] R1_DIN;
  logic              R1_ACK;
  logic              R1_W;
  logic              R1_DOUTEN;

  // Current owner, one-hot
  logic [1:0]        GNT;

  // DRAMCON user port
  logic [1:0]        D_REQ;
  logic [ADDR_W-1:0] D_INITADR;
  logic [ADDR_W-1:0] D_ELEM;
  logic [DATA_W-1:0] D_DIN;
  logic              D_BUSY;
  logic              D_W;
  logic              D_DOUTEN;

  modport slave (
    input  R0_REQ, R0_INITADR, R0_BLOCKS, R0_DIN,
    input  R1_REQ, R1_INITADR, R1_BLOCKS, R1_DIN,
    output R0_ACK, R0_W, R0_DOUTEN,
    output R1_ACK, R1_W, R1_DOUTEN,
    output GNT,
    output D_REQ, D_INITADR, D_ELEM, D_DIN,
    input  D_BUSY, D_W, D_DOUTEN
  );

  modport master (
    output R0_REQ, R0_INITADR, R0_BLOCKS, R0_DIN,
    output R1_REQ, R1_INITADR, R1_BLOCKS, R1_DIN,
    input  R0_ACK, R0_W, R0_DOUTEN,
    input  R1_ACK, R1_W, R1_DOUTEN,
    input  GNT,
    input  D_REQ, D_INITADR, D_ELEM, D_DIN,
    output D_BUSY, D_W, D_DOUTEN
  );

endinterface

// File: rtl/dram_arbiter_arb_pick.sv
// Two-way winner select for the DRAM arbiter.
// ARB_ROUNDROBIN_EN defined: ties go to the requester that did not win last;
// the preference pointer moves on every grant.
// ARB_ROUNDROBIN_EN undefined: fixed priority, requester 0 wins ties.
module dram_arbiter_arb_pick (
`ifdef ARB_ROUNDROBIN_EN
  input  logic       clk,
  input  logic       rst_n,
  input  logic       grant_i,
`endif
  input  logic [1:0] valid_i,
  output logic [1:0] win_o
);

`ifdef ARB_ROUNDROBIN_EN
  // Index of the requester that wins the next tie.
  logic ptr_q;

  // One-hot winner, tie broken by the pointer.
  // NOTE: give every always_comb output a default first so no path leaves it unassigned (latch).
  always_comb begin
    win_o = valid_i;
    if (valid_i == 2'b11) begin
      win_o = ptr_q ? 2'b10 : 2'b01;
    end
  end

  // Prefer the loser of each grant next time.
  // NOTE: sequential state uses non-blocking assignments and an async active-low reset term.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else if (grant_i) begin
      ptr_q <= ~win_o[1];
    end
  end
`else
  // Fixed priority: requester 0 first.
  always_comb begin
    win_o = valid_i;
    if (valid_i[0]) begin
      win_o = 2'b01;
    end
  end
`endif

endmodule

// File: rtl/dram_arbiter.sv
// Shares the DRAMCON user port between the sort core (R0) and the
// read-back / LCD dump engine (R1). One transaction at a time: grant,
// pulse D_REQ for one cycle, then hold ownership until DRAMCON has raised
// and dropped D_BUSY. Write pulls and read valids go to the owner only.
// Build option: ARB_ROUNDROBIN_EN selects round-robin tie breaking
// (default is fixed priority with R0 first).
module dram_arbiter
  import dram_arbiter_pkg::*;
#(
  parameter int DATA_W = 512,
  parameter int ADDR_W = 32
) (
  input logic           CLK,
  input logic           RST_X,
  dram_arbiter_if.slave bus
);

  arb_state_e        state_q;
  logic [1:0]        gnt_q;
  logic [1:0]        ack_q;
  logic [1:0]        d_req_q;
  logic [ADDR_W-1:0] d_initadr_q;
  logic [ADDR_W-1:0] d_elem_q;

  logic [1:0]        req_valid;
  logic [1:0]        gnt_d;
  logic              grant_go;
  logic [DATA_W-1:0] din_sel;

  assign req_valid = {is_valid_req(bus.R1_REQ), is_valid_req(bus.R0_REQ)};
  // Grants happen only from IDLE while DRAMCON is not busy.
  assign grant_go  = (state_q == IDLE) && !bus.D_BUSY && (|req_valid);

  dram_arbiter_arb_pick u_arb_pick (
`ifdef ARB_ROUNDROBIN_EN
    .clk     (CLK),
    .rst_n   (RST_X),
    .grant_i (grant_go),
`endif
    .valid_i (req_valid),
    .win_o   (gnt_d)
  );

  // Transaction FSM with registered DRAMCON command, grant and ACK outputs.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state_q     <= IDLE;
      gnt_q       <= 2'b00;
      ack_q       <= 2'b00;
      d_req_q     <= REQ_NONE;
      d_initadr_q <= '0;
      d_elem_q    <= '0;
    end else begin
      ack_q <= 2'b00;
      unique case (state_q)
        IDLE: begin
          if (grant_go) begin
            gnt_q       <= gnt_d;
            ack_q       <= gnt_d;
            d_req_q     <= gnt_d[1] ? bus.R1_REQ     : bus.R0_REQ;
            d_initadr_q <= gnt_d[1] ? bus.R1_INITADR : bus.R0_INITADR;
            d_elem_q    <= gnt_d[1] ? bus.R1_BLOCKS  : bus.R0_BLOCKS;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          d_req_q <= REQ_NONE;
          state_q <= WAITHI;
        end
        WAITHI: begin
          if (bus.D_BUSY) begin
            state_q <= WAITLO;
          end
        end
        WAITLO: begin
          if (!bus.D_BUSY) begin
            gnt_q   <= 2'b00;
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  // Write data follows the owner; R0 is the default when idle.
  assign din_sel = gnt_q[1] ? bus.R1_DIN : bus.R0_DIN;

  assign bus.D_DIN     = din_sel;
  assign bus.D_REQ     = d_req_q;
  assign bus.D_INITADR = d_initadr_q;
  assign bus.D_ELEM    = d_elem_q;
  assign bus.GNT       = gnt_q;
  assign bus.R0_ACK    = ack_q[0];
  assign bus.R1_ACK    = ack_q[1];
  // Strobes with no owner are dropped.
  assign bus.R0_W      = bus.D_W & gnt_q[0];
  assign bus.R1_W      = bus.D_W & gnt_q[1];
  assign bus.R0_DOUTEN = bus.D_DOUTEN & gnt_q[0];
  assign bus.R1_DOUTEN = bus.D_DOUTEN & gnt_q[1];

endmodule

// File: tb/tb_dram_arbiter.sv
// Self-checking bench for dram_arbiter: directed scenarios with literal
// expectations, then randomized requesters and a DRAMCON responder, all
// compared each cycle against a transaction-level model of the arbiter.
// Honours ARB_ROUNDROBIN_EN to match the RTL build.
module tb_dram_arbiter;

  localparam int DATA_W = 512;
  localparam int ADDR_W = 32;

  logic CLK   = 1'b0;
  logic RST_X = 1'b0;

  dram_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  dram_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .CLK   (CLK),
    .RST_X (RST_X),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit valid_code(input logic [1:0] c);
    return (c == 2'b01) || (c == 2'b10);
  endfunction

  function automatic logic [DATA_W-1:0] rand_data();
    logic [DATA_W-1:0] d;
    for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // ---------------- transaction-level reference model ----------------
  int                m_owner = -1;   // -1: nobody owns the port
  int                m_age   = 0;    // edges since the grant (saturates at 1)
  bit                m_seen  = 1'b0; // DRAMCON has shown busy for this txn
  logic [1:0]        m_code  = 2'b00;
  logic [ADDR_W-1:0] m_adr   = '0;
  logic [ADDR_W-1:0] m_elem  = '0;
  logic [1:0]        m_ack   = 2'b00;
`ifdef ARB_ROUNDROBIN_EN
  int                m_next  = 0;    // who wins the next tie
`endif

  always @(posedge CLK or negedge RST_X) begin : model
    bit v0, v1;
    int w;
    if (!RST_X) begin
      m_owner = -1; m_age = 0; m_seen = 0; m_code = 2'b00;
      m_adr = '0; m_elem = '0; m_ack = 2'b00;
`ifdef ARB_ROUNDROBIN_EN
      m_next = 0;
`endif
    end else begin
      m_ack = 2'b00;
      if (m_owner < 0) begin
        v0 = valid_code(bus.R0_REQ);
        v1 = valid_code(bus.R1_REQ);
        if (!bus.D_BUSY && (v0 || v1)) begin
`ifdef ARB_ROUNDROBIN_EN
          w = (v0 && v1) ? m_next : (v0 ? 0 : 1);
          m_next = 1 - w;
`else
          w = v0 ? 0 : 1;
`endif
          m_owner = w; m_age = 0; m_seen = 0;
          m_code = w ? bus.R1_REQ : bus.R0_REQ;
          m_adr  = w ? bus.R1_INITADR : bus.R0_INITADR;
          m_elem = w ? bus.R1_BLOCKS : bus.R0_BLOCKS;
          m_ack[w] = 1'b1;
        end
      end else if (m_age == 0) begin
        m_age = 1;
      end else if (!m_seen) begin
        if (bus.D_BUSY) m_seen = 1;
      end else if (!bus.D_BUSY) begin
        m_owner = -1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit cmp_en = 1'b0;

  always @(posedge CLK) begin
    #4;
    if (cmp_en) begin
      check("GNT", bus.GNT, (m_owner < 0) ? 2'b00 : ((m_owner == 0) ? 2'b01 : 2'b10));
      check("D_REQ", bus.D_REQ, (m_owner >= 0 && m_age == 0) ? m_code : 2'b00);
      check("D_INITADR", bus.D_INITADR, m_adr);
      check("D_ELEM", bus.D_ELEM, m_elem);
      check("R0_ACK", bus.R0_ACK, m_ack[0]);
      check("R1_ACK", bus.R1_ACK, m_ack[1]);
      check("R0_W", bus.R0_W, bus.D_W && (m_owner == 0));
      check("R1_W", bus.R1_W, bus.D_W && (m_owner == 1));
      check("R0_DOUTEN", bus.R0_DOUTEN, bus.D_DOUTEN && (m_owner == 0));
      check("R1_DOUTEN", bus.R1_DOUTEN, bus.D_DOUTEN && (m_owner == 1));
      check("D_DIN", bus.D_DIN, (m_owner == 1) ? bus.R1_DIN : bus.R0_DIN);
    end
  end

  // Strobe counters for the directed transfer-count checks.
  int c_r0w = 0, c_r1w = 0, c_r0d = 0, c_r1d = 0;

  always @(posedge CLK) begin
    #4;
    c_r0w += int'(bus.R0_W);
    c_r1w += int'(bus.R1_W);
    c_r0d += int'(bus.R0_DOUTEN);
    c_r1d += int'(bus.R1_DOUTEN);
  end

  // ---------------- DRAMCON responder and requesters ----------------
  int dc_state  = 0;     // 0 idle, 1 request seen, 2 busy/bursting
  int dc_left   = 0;
  int dc_forced = 0;     // >0: fixed burst length
  int dc_spont  = 0;
  bit dc_quiet  = 1'b1;  // no spontaneous busy/strays, burst every cycle
  bit dc_wr     = 1'b0;
  bit req_auto  = 1'b0;
  bit pend [2]  = '{1'b0, 1'b0};

  task automatic set_req(input int n, input logic [1:0] code);
    if (n == 0) bus.R0_REQ = code;
    else        bus.R1_REQ = code;
  endtask

  task automatic new_req(input int n, input logic [1:0] code);
    set_req(n, code);
    if (n == 0) begin
      bus.R0_INITADR = $urandom;
      bus.R0_BLOCKS  = $urandom_range(1, 64);
    end else begin
      bus.R1_INITADR = $urandom;
      bus.R1_BLOCKS  = $urandom_range(1, 64);
    end
  endtask

  function automatic logic [1:0] rand_code();
    return ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
  endfunction

  task automatic clear_counts();
    c_r0w = 0; c_r1w = 0; c_r0d = 0; c_r1d = 0;
  endtask

  // Advance one cycle; drive new inputs 2 time units after the edge.
  task automatic tick();
    @(posedge CLK);
    #2;
    bus.D_W = 1'b0;
    bus.D_DOUTEN = 1'b0;
    case (dc_state)
      0: begin
        if (bus.D_REQ != 2'b00) begin
          dc_wr    = (bus.D_REQ == 2'b10);
          dc_left  = (dc_forced > 0) ? dc_forced : int'($urandom_range(1, 8));
          dc_state = 1;
        end else if (!dc_quiet && bus.GNT == 2'b00) begin
          if (dc_spont > 0) begin
            dc_spont--;
            if (dc_spont == 0) bus.D_BUSY = 1'b0;
          end else if ($urandom_range(0, 29) == 0) begin
            bus.D_BUSY = 1'b1;
            dc_spont = $urandom_range(1, 4);
          end
          if ($urandom_range(0, 14) == 0) bus.D_W = 1'b1;
          if ($urandom_range(0, 14) == 0) bus.D_DOUTEN = 1'b1;
        end
      end
      1: begin
        bus.D_BUSY = 1'b1;
        dc_state = 2;
      end
      default: begin
        if (dc_left > 0) begin
          if (dc_quiet || $urandom_range(0, 1) == 1) begin
            if (dc_wr) bus.D_W = 1'b1;
            else       bus.D_DOUTEN = 1'b1;
            dc_left--;
          end
        end else begin
          bus.D_BUSY = 1'b0;
          dc_state = 0;
        end
      end
    endcase
    if (req_auto) begin
      bus.R0_DIN = rand_data();
      bus.R1_DIN = rand_data();
      for (int n = 0; n < 2; n++) begin
        logic a;
        a = (n == 0) ? bus.R0_ACK : bus.R1_ACK;
        if (pend[n] && a) begin
          if ($urandom_range(0, 1) == 1) new_req(n, rand_code());
          else begin set_req(n, 2'b00); pend[n] = 0; end
        end else if (pend[n]) begin
          if ($urandom_range(0, 24) == 0) begin set_req(n, 2'b00); pend[n] = 0; end
        end else begin
          int r;
          r = $urandom_range(0, 9);
          if (r < 3)       begin new_req(n, rand_code()); pend[n] = 1; end
          else if (r == 3) set_req(n, 2'b11);
          else             set_req(n, 2'b00);
        end
      end
    end
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while ((bus.GNT != 2'b00 || dc_state != 0) && k < 60) begin
      tick();
      k++;
    end
    check(name, bus.GNT, 2'b00);
  endtask

  task automatic wait_ack(input string name);
    int k;
    k = 0;
    while (!(bus.R0_ACK || bus.R1_ACK) && k < 30) begin
      tick();
      k++;
    end
    if (k >= 30) check({name, "_timeout"}, {bus.R1_ACK, bus.R0_ACK}, 2'b01);
  endtask

  // ---------------- directed then random stimulus ----------------
  initial begin
    logic [1:0] t2_exp [3];
`ifdef ARB_ROUNDROBIN_EN
    t2_exp = '{2'b01, 2'b10, 2'b01};
`else
    t2_exp = '{2'b01, 2'b01, 2'b01};
`endif
    bus.R0_REQ = 2'b00; bus.R0_INITADR = '0; bus.R0_BLOCKS = '0; bus.R0_DIN = '0;
    bus.R1_REQ = 2'b00; bus.R1_INITADR = '0; bus.R1_BLOCKS = '0; bus.R1_DIN = '0;
    bus.D_BUSY = 1'b0; bus.D_W = 1'b0; bus.D_DOUTEN = 1'b0;

    // Reset values
    tick();
    check("rst_gnt", bus.GNT, 2'b00);
    check("rst_dreq", bus.D_REQ, 2'b00);
    check("rst_adr", bus.D_INITADR, 0);
    check("rst_elem", bus.D_ELEM, 0);
    check("rst_ack", {bus.R1_ACK, bus.R0_ACK}, 2'b00);
    cmp_en = 1'b1;
    RST_X = 1'b1;

    // Single R0 read, 8 read beats
    clear_counts();
    dc_forced = 8;
    bus.R0_REQ = 2'b01; bus.R0_INITADR = 32'h1000; bus.R0_BLOCKS = 32'd4;
    tick();
    check("t1_ack", bus.R0_ACK, 1'b1);
    check("t1_dreq", bus.D_REQ, 2'b01);
    check("t1_adr", bus.D_INITADR, 32'h1000);
    check("t1_elem", bus.D_ELEM, 32'd4);
    check("t1_gnt", bus.GNT, 2'b01);
    bus.R0_REQ = 2'b00;
    tick();
    check("t1_dreq_drop", bus.D_REQ, 2'b00);
    wait_idle("t4_idle");
    check("t4_r0_douten", c_r0d, 8);
    check("t4_r1_douten", c_r1d, 0);

    // R1 write right after the port frees, 4 write pulls
    clear_counts();
    dc_forced = 4;
    bus.R0_DIN = rand_data();
    bus.R1_DIN = rand_data();
    bus.R1_REQ = 2'b10; bus.R1_INITADR = 32'h2000; bus.R1_BLOCKS = 32'd4;
    tick();
    check("t3_ack_next", bus.R1_ACK, 1'b1);
    check("t3_gnt", bus.GNT, 2'b10);
    bus.R1_REQ = 2'b00;
    wait_idle("t3_idle");
    check("t3_r1_w", c_r1w, 4);
    check("t3_r0_w", c_r0w, 0);

    // Async reset in WAITLO with R1 pending
    dc_forced = 8;
    bus.R0_REQ = 2'b01; bus.R0_INITADR = 32'h3000; bus.R0_BLOCKS = 32'd8;
    tick();
    check("t6_ack", bus.R0_ACK, 1'b1);
    bus.R0_REQ = 2'b00;
    bus.R1_REQ = 2'b01; bus.R1_INITADR = 32'h4000; bus.R1_BLOCKS = 32'd2;
    tick();
    tick();
    #1 RST_X = 1'b0;
    #1;
    check("t6_rst_gnt", bus.GNT, 2'b00);
    check("t6_rst_dreq", bus.D_REQ, 2'b00);
    check("t6_rst_adr", bus.D_INITADR, 0);
    check("t6_rst_elem", bus.D_ELEM, 0);
    dc_state = 0; bus.D_W = 1'b0; bus.D_DOUTEN = 1'b0;
    tick();
    RST_X = 1'b1;
    bus.D_BUSY = 1'b0;
    tick();
    check("t6_r1_ack", bus.R1_ACK, 1'b1);
    check("t6_r1_gnt", bus.GNT, 2'b10);
    bus.R1_REQ = 2'b00;
    dc_forced = 1;
    wait_idle("t6_idle");

    // Simultaneous requests over three rounds
    bus.R0_REQ = 2'b01; bus.R0_INITADR = 32'h5000; bus.R0_BLOCKS = 32'd1;
    bus.R1_REQ = 2'b01; bus.R1_INITADR = 32'h6000; bus.R1_BLOCKS = 32'd1;
    for (int r = 0; r < 3; r++) begin
      wait_ack("t2_wait");
      check("t2_round", {bus.R1_ACK, bus.R0_ACK}, t2_exp[r]);
      tick();
    end
    bus.R0_REQ = 2'b00;
    bus.R1_REQ = 2'b00;
    wait_idle("t2_idle");

    // Busy blocks grants
    bus.D_BUSY = 1'b1;
    dc_forced = 2;
    bus.R0_REQ = 2'b10; bus.R0_INITADR = 32'h7000; bus.R0_BLOCKS = 32'd2;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_blocked", bus.R0_ACK, 1'b0);
    end
    bus.D_BUSY = 1'b0;
    tick();
    check("t5_ack", bus.R0_ACK, 1'b1);
    bus.R0_REQ = 2'b00;
    wait_idle("t5_idle");

    // Randomized traffic
    dc_forced = 0;
    dc_quiet  = 1'b0;
    req_auto  = 1'b1;
    repeat (3000) tick();
    req_auto = 1'b0;
    bus.R0_REQ = 2'b00;
    bus.R1_REQ = 2'b00;
    dc_quiet = 1'b1;
    if (dc_state == 0) bus.D_BUSY = 1'b0;
    dc_spont = 0;
    wait_idle("final_idle");
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dram_arbiter.md
Name: dram_arbiter

Overview:
- Shares the single DRAMCON user port (D_REQ/D_INITADR/D_ELEM/D_BUSY/D_DIN/D_W/D_DOUTEN) between two requesters.
  - Requester 0: sort core.
  - Requester 1: verification read-back or LCD dump engine.
- Replaces the ad-hoc pcnt_halt mux in the top level.
- Accepts one transaction at a time, issues it to DRAMCON, and holds ownership until DRAMCON drops busy.
- Routes write-data pulls and read-data valids to the owning requester only.

Parameters:
- DATA_W, 512, width of DRAM app data (APPDATA_WIDTH).
- ADDR_W, 32, width of initial address and block count.

Ports:
- CLK  in  1  user clock (CLK100M domain).
- RST_X  in  1  reset, asynchronous, active-low.
- R0_REQ / R1_REQ  in  2  request code: 00 none, 01 read, 10 write, 11 reserved (treated as none).
- R0_INITADR / R1_INITADR  in  ADDR_W  start address.
- R0_BLOCKS / R1_BLOCKS  in  ADDR_W  burst block count.
- R0_DIN / R1_DIN  in  DATA_W  write data.
- R0_ACK / R1_ACK  out  1  one-cycle pulse: request accepted.
- R0_W / R1_W  out  1  write-data pull (gated D_W).
- R0_DOUTEN / R1_DOUTEN  out  1  read-data valid (gated D_DOUTEN).
- GNT  out  2  one-hot current owner; 00 when idle.
- D_REQ  out  2  to DRAMCON.
- D_INITADR  out  ADDR_W  to DRAMCON.
- D_ELEM  out  ADDR_W  to DRAMCON.
- D_DIN  out  DATA_W  to DRAMCON.
- D_BUSY  in  1  from DRAMCON.
- D_W  in  1  from DRAMCON.
- D_DOUTEN  in  1  from DRAMCON.

D_DOUT is not routed; it fans out directly to both requesters.

Behaviour:
- Reset (RST_X low, async): state IDLE, GNT=00, D_REQ=0, D_INITADR=0, D_ELEM=0, all ACK=0, rr pointer=0.
- States:
  - IDLE: if !D_BUSY and a valid request is present, select a winner, register its INITADR/BLOCKS/REQ into D_*, set GNT, pulse its ACK, and go to ISSUE. Latency is 1 cycle from request to D_REQ.
  - ISSUE: D_REQ is held for exactly this one cycle, then D_REQ←0 and go to WAITHI.
  - WAITHI: wait for D_BUSY=1, then go to WAITLO. There is no timeout, because DRAMCON raises busy the cycle after the request.
  - WAITLO: wait for D_BUSY=0, then GNT←00 and go to IDLE. The next grant is possible on the following cycle.
- Handshake: a requester holds REQ/INITADR/BLOCKS stable until its ACK. It drops REQ in the cycle after ACK, or immediately issues a new request.
  - The arbiter ignores REQ outside IDLE.
  - A request withdrawn before ACK is legal and simply never granted.
- Routing:
  - Rn_W = D_W & GNT[n].
  - Rn_DOUTEN = D_DOUTEN & GNT[n].
  - D_DIN = GNT[1] ? R1_DIN : R0_DIN (combinational).
  - D_W or D_DOUTEN asserted while GNT=00 is dropped. Verification flags it as an error.
- Simultaneous requests in IDLE are resolved per the Optional Feature; exactly one ACK fires.
- D_BUSY high in IDLE blocks all grants.
- Reset asserted mid-transaction returns to IDLE with GNT=00 regardless of D_BUSY.

Optional Feature:
- ARB_ROUNDROBIN_EN defined: round-robin arbitration.
  - On a tie the non-last winner gets the grant.
  - The rr pointer updates on every grant.
- Undefined: fixed priority, R0 always wins ties. The rr pointer logic is absent.

Decomposition:
- Shared package/define file holds:
  - REQ codes: REQ_NONE=2'b00, REQ_READ=2'b01, REQ_WRITE=2'b10.
  - State encodings: IDLE, ISSUE, WAITHI, WAITLO.
- One natural sub-module, arb_pick (2-way winner select with optional rr pointer), instantiated once.

Test Plan:
1. R0_REQ=01, adr=0x1000, blocks=4, D_BUSY=0 → next cycle R0_ACK=1, D_REQ=01, D_INITADR=0x1000, D_ELEM=4, GNT=01. D_REQ=0 one cycle later.
2. Both REQ=01 in the same cycle, round-robin build → grants R0, then R1, then R0 across three rounds. Fixed-priority build → R0 three times while R0 keeps requesting.
3. R1 owns a write; DRAMCON pulses D_W 4 times → R1_W pulses 4, R0_W stays 0, D_DIN equals R1_DIN on each pulse.
4. R0 owns a read; D_DOUTEN pulses 8 times → R0_DOUTEN 8, R1_DOUTEN 0. After D_BUSY falls, GNT=00 and R1 is grantable the next cycle.
5. D_BUSY held high, R0_REQ=10 → no ACK until D_BUSY falls, then ACK within 1 cycle.
6. RST_X pulsed low while in WAITLO → all outputs reach reset values immediately (async). After release, a pending R1 request is granted normally.
